// File: rtl/jt49_bus_arb_pkg.sv
// Shared definitions for the two-port jt49 register-bus arbiter:
// FSM state encoding, port identifiers and the round-robin pick.
package jt49_bus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // With both ports requesting, the port not granted last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    else if (req1)    return PORT1;
    else              return PORT0;
  endfunction

endpackage

// File: rtl/jt49_bus_arb.sv
// Two-requester arbiter in front of the single jt49 register port, with
// per-register write protection for port 1 and an optional idle gap per access.
module jt49_bus_arb
  import jt49_bus_arb_pkg::*;
#(
  parameter int          GAP     = 0,
  parameter logic [15:0] WPMASK1 = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       wr0,
  input  logic [3:0] addr0,
  input  logic [7:0] din0,
  output logic       ack0,
  input  logic       req1,
  input  logic       wr1,
  input  logic [3:0] addr1,
  input  logic [7:0] din1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  input  logic [7:0] psg_dout
);

  localparam logic [3:0] GAP_LD = 4'(GAP);

  arb_state_t r_state;
  logic       r_last;
  logic       r_gid;
  logic       r_drop;
  logic [3:0] r_gap_cnt;

  logic       w_gid;
  logic       w_wr;
  logic [3:0] w_addr;
  logic [7:0] w_din;
  logic       w_drop;

  assign w_gid  = rr_pick(req0, req1, r_last);
  assign w_wr   = (w_gid == PORT1) ? wr1   : wr0;
  assign w_addr = (w_gid == PORT1) ? addr1 : addr0;
  assign w_din  = (w_gid == PORT1) ? din1  : din0;
  // Protected port-1 writes still run the full sequence but never reach the PSG.
  assign w_drop = (w_gid == PORT1) && w_wr && WPMASK1[w_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= PORT1;
      r_gid     <= PORT0;
      r_drop    <= 1'b0;
      r_gap_cnt <= 4'd0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= 8'h00;
      busy      <= 1'b0;
      psg_addr  <= 4'd0;
      psg_din   <= 8'h00;
      psg_cs_n  <= 1'b1;
      psg_wr_n  <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 || req1) begin
            r_state  <= ST_ACC;
            busy     <= 1'b1;
            r_last   <= w_gid;
            r_gid    <= w_gid;
            r_drop   <= w_drop;
            psg_addr <= w_addr;
            psg_din  <= w_din;
            psg_cs_n <= w_drop;
            psg_wr_n <= ~w_wr | w_drop;
          end
        end
        ST_ACC: begin
          r_state  <= ST_WAIT;
          psg_cs_n <= 1'b1;
          psg_wr_n <= 1'b1;
        end
        ST_WAIT: begin
          r_state <= ST_DONE;
          rdata   <= r_drop ? 8'h00 : psg_dout;
          ack0    <= (r_gid == PORT0);
          ack1    <= (r_gid == PORT1);
        end
        ST_DONE: begin
          if (GAP_LD == 4'd0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state   <= ST_GAP;
            r_gap_cnt <= GAP_LD;
          end
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
          if (r_gap_cnt <= 4'd1) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Scoreboard bench for jt49_bus_arb: a behavioural jt49 register file answers the
// PSG bus, stimulus pushes expected acks, a monitor pops and compares them.
module tb_jt49_bus_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [3:0] addr0 = 4'd0, addr1 = 4'd0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       ack0, ack1, busy, psg_cs_n, psg_wr_n;
  logic [7:0] rdata, psg_din;
  logic [3:0] psg_addr;
  logic [7:0] psg_dout;

  jt49_bus_arb #(.GAP(3), .WPMASK1(16'h0080)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .din0(din0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .din1(din1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .psg_addr(psg_addr), .psg_din(psg_din), .psg_cs_n(psg_cs_n), .psg_wr_n(psg_wr_n),
    .psg_dout(psg_dout)
  );

  always #5 clk = ~clk;

  // jt49 register port: read-before-write, dout registered one cycle after cs_n low
  logic [7:0] m_regs [16];
  logic       model_clr = 1'b1;
  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 8'h00;
      psg_dout <= 8'h00;
    end else if (!psg_cs_n) begin
      psg_dout <= m_regs[psg_addr];
      if (!psg_wr_n) m_regs[psg_addr] <= psg_din;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       port;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic expect_ack(input logic port, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  int   adj_viol = 0;
  logic prev_cs_low = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, expected none", ack0, ack1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
          chk("ack_port", 32'(ack1), 32'(e.port));
          chk("ack_rdata", 32'(rdata), 32'(e.data));
        end
      end
      if (!psg_cs_n && prev_cs_low) adj_viol++;
    end
    prev_cs_low <= !psg_cs_n && !rst;
  end

  int         ack_t0[$], ack_t1[$], cs_t[$];
  logic       cs_wr_n;
  logic [3:0] cs_addr;
  logic [7:0] cs_din;

  // Runs until port 0 has seen n0 acks and port 1 n1 acks, dropping each req
  // after its last ack, then waits for the arbiter to go idle.
  task automatic serve(input int n0, input int n1);
    ack_t0.delete();
    ack_t1.delete();
    cs_t.delete();
    for (int i = 0; i < 200 && (ack_t0.size() < n0 || ack_t1.size() < n1); i++) begin
      @(negedge clk);
      if (!psg_cs_n) begin
        if (cs_t.size() == 0) begin
          cs_wr_n = psg_wr_n;
          cs_addr = psg_addr;
          cs_din  = psg_din;
        end
        cs_t.push_back(cyc);
      end
      if (ack0) begin
        ack_t0.push_back(cyc);
        if (ack_t0.size() >= n0) req0 = 1'b0;
      end
      if (ack1) begin
        ack_t1.push_back(cyc);
        if (ack_t1.size() >= n1) req1 = 1'b0;
      end
    end
    chk("serve_ack0_count", 32'(ack_t0.size()), 32'(n0));
    chk("serve_ack1_count", 32'(ack_t1.size()), 32'(n1));
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("serve_idle", 32'(busy), 32'd0);
  endtask

  task automatic set0(input logic w, input logic [3:0] a, input logic [7:0] d);
    req0 = 1'b1; wr0 = w; addr0 = a; din0 = d;
  endtask

  task automatic set1(input logic w, input logic [3:0] a, input logic [7:0] d);
    req1 = 1'b1; wr1 = w; addr1 = a; din1 = d;
  endtask

  int t_req;

  initial begin
    repeat (3) @(negedge clk);
    // reset values
    chk("rst_cs_n", 32'(psg_cs_n), 32'd1);
    chk("rst_wr_n", 32'(psg_wr_n), 32'd1);
    chk("rst_addr", 32'(psg_addr), 32'd0);
    chk("rst_din", 32'(psg_din), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    model_clr = 1'b0;
    @(negedge clk);

    // both ports together right after reset: port 0 first, then port 1, 7 cycles apart
    set0(1'b1, 4'd1, 8'h11); expect_ack(1'b0, 8'h00);
    set1(1'b1, 4'd2, 8'h22); expect_ack(1'b1, 8'h00);
    serve(1, 1);
    chk("rr_first_p0_spacing", 32'(ack_t1[0] - ack_t0[0]), 32'd7);

    // lone port 0 write R8=0F: cs_n low at k+1 only, ack at k+3
    t_req = cyc;
    set0(1'b1, 4'd8, 8'h0F); expect_ack(1'b0, 8'h00);
    serve(1, 0);
    chk("w8_cs_count", 32'(cs_t.size()), 32'd1);
    chk("w8_cs_cycle", 32'(cs_t[0] - t_req), 32'd1);
    chk("w8_wr_n", 32'(cs_wr_n), 32'd0);
    chk("w8_addr", 32'(cs_addr), 32'd8);
    chk("w8_din", 32'(cs_din), 32'h0F);
    chk("w8_ack_latency", 32'(ack_t0[0] - t_req), 32'd3);

    set0(1'b0, 4'd8, 8'h00); expect_ack(1'b0, 8'h0F);
    serve(1, 0);

    // protected port 1 write to R7: no PSG access, still acked at k+3 with 00
    t_req = cyc;
    set1(1'b1, 4'd7, 8'h33); expect_ack(1'b1, 8'h00);
    serve(0, 1);
    chk("wp_cs_count", 32'(cs_t.size()), 32'd0);
    chk("wp_ack_latency", 32'(ack_t1[0] - t_req), 32'd3);
    set0(1'b0, 4'd7, 8'h00); expect_ack(1'b0, 8'h00);
    serve(1, 0);
    chk("wp_model_r7", 32'(m_regs[7]), 32'h00);

    // write R0 via port 0, then both read; port 1 was not last so it goes first
    set0(1'b1, 4'd0, 8'h5A); expect_ack(1'b0, 8'h00);
    serve(1, 0);
    set1(1'b0, 4'd0, 8'h00); expect_ack(1'b1, 8'h5A);
    set0(1'b0, 4'd1, 8'h00); expect_ack(1'b0, 8'h11);
    serve(1, 1);
    chk("rr_alt_spacing", 32'(ack_t0[0] - ack_t1[0]), 32'd7);

    // reset during ACC abandons the access without an ack
    set0(1'b1, 4'd3, 8'h77);
    @(negedge clk);
    chk("acc_cs_low", 32'(psg_cs_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(psg_cs_n), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    req0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_ack", 32'({ack0, ack1}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    set0(1'b0, 4'd3, 8'h00); expect_ack(1'b0, 8'h00);
    serve(1, 0);
    chk("arst_r3_unwritten", 32'(m_regs[3]), 32'h00);

    // req0 held high: ack every 7 cycles
    set0(1'b0, 4'd8, 8'h00);
    repeat (4) expect_ack(1'b0, 8'h0F);
    serve(4, 0);
    for (int i = 1; i < 4; i++)
      chk("cont_spacing", 32'(ack_t0[i] - ack_t0[i-1]), 32'd7);

    repeat (3) @(negedge clk);
    chk("cs_adjacent", 32'(adj_viol), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
